bc_duplex_buffer: RTL and testbench

Parametrised two-direction breadcrumb buffer between the control path and the Avoidance block. Contains two independent, identical inferred FIFOs with no vendor IP:
- `in`: control → Avoidance.
- `out`: Avoidance → control.

Each FIFO has configurable width and depth, an almost-full threshold, an occupancy count, a synchronous flush and a registered read with a valid strobe.

---
 rtl/bc_duplex_buffer.sv | 207 ++++++++++++++++++++
 tb/tb_bc_duplex_buffer.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bc_duplex_buffer.sv
// bc_duplex_buffer
//
// Two independent breadcrumb FIFOs sharing one clock and reset:
//   in  : control -> Avoidance
//   out : Avoidance -> control
// Each direction is an inferred DEPTH x WIDTH FIFO with registered read data and
// a valid strobe, an occupancy count, full/almost-full/empty flags and a
// synchronous flush.
//
// Ports (per direction d in {in, out}):
//   clk, rst       shared clock, asynchronous active-low reset
//   d_wr_en/d_din  write request and data
//   d_rd_en        read request; d_dout/d_valid update one cycle later
//   d_flush        synchronous clear of that direction
//   d_full/d_afull/d_empty/d_count  occupancy status
//   d_ovf/d_unf    sticky overflow/underflow, only with BC_BUF_ERR_FLAGS_EN
//
// Optional feature macro: BC_BUF_ERR_FLAGS_EN (adds the sticky error flags).

module bc_duplex_buffer #(
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned DEPTH        = 1024,
    parameter int unsigned AFULL_THRESH = 768
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_wr_en,
    input  logic [WIDTH-1:0]        in_din,
    input  logic                    in_rd_en,
    input  logic                    in_flush,
    output logic [WIDTH-1:0]        in_dout,
    output logic                    in_valid,
    output logic                    in_full,
    output logic                    in_afull,
    output logic                    in_empty,
    output logic [$clog2(DEPTH):0]  in_count,
    input  logic                    out_wr_en,
    input  logic [WIDTH-1:0]        out_din,
    input  logic                    out_rd_en,
    input  logic                    out_flush,
    output logic [WIDTH-1:0]        out_dout,
    output logic                    out_valid,
    output logic                    out_full,
    output logic                    out_afull,
    output logic                    out_empty,
    output logic [$clog2(DEPTH):0]  out_count
`ifdef BC_BUF_ERR_FLAGS_EN
    ,
    output logic                    in_ovf,
    output logic                    in_unf,
    output logic                    out_ovf,
    output logic                    out_unf
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    // Index 0 is the in direction, index 1 the out direction.
    logic             wr_en_a [2];
    logic             rd_en_a [2];
    logic             flush_a [2];
    logic [WIDTH-1:0] din_a   [2];
    logic [WIDTH-1:0] dout_a  [2];
    logic             valid_a [2];
    logic             full_a  [2];
    logic             afull_a [2];
    logic             empty_a [2];
    logic [CW-1:0]    count_a [2];

    assign wr_en_a[0] = in_wr_en;
    assign wr_en_a[1] = out_wr_en;
    assign rd_en_a[0] = in_rd_en;
    assign rd_en_a[1] = out_rd_en;
    assign flush_a[0] = in_flush;
    assign flush_a[1] = out_flush;
    assign din_a[0]   = in_din;
    assign din_a[1]   = out_din;

    assign in_dout   = dout_a[0];
    assign in_valid  = valid_a[0];
    assign in_full   = full_a[0];
    assign in_afull  = afull_a[0];
    assign in_empty  = empty_a[0];
    assign in_count  = count_a[0];
    assign out_dout  = dout_a[1];
    assign out_valid = valid_a[1];
    assign out_full  = full_a[1];
    assign out_afull = afull_a[1];
    assign out_empty = empty_a[1];
    assign out_count = count_a[1];

`ifdef BC_BUF_ERR_FLAGS_EN
    logic ovf_a [2];
    logic unf_a [2];
    assign in_ovf  = ovf_a[0];
    assign in_unf  = unf_a[0];
    assign out_ovf = ovf_a[1];
    assign out_unf = unf_a[1];
`endif

    for (genvar g = 0; g < 2; g++) begin : g_dir
        logic [WIDTH-1:0] mem [DEPTH];
        logic [AW-1:0]    wp_q, wp_d, rp_q, rp_d;
        logic [CW-1:0]    count_q, count_d;
        logic [WIDTH-1:0] dout_q, dout_d;
        logic             valid_q, valid_d;
        logic             full, empty, rd_ok, wr_ok;

        assign full  = (count_q == CW'(DEPTH));
        assign empty = (count_q == '0);
        assign rd_ok = rd_en_a[g] && !empty;
        // A read in the same cycle frees a slot, so a write while full still lands.
        assign wr_ok = wr_en_a[g] && (!full || rd_ok);

        always_comb begin
            wp_d    = wp_q;
            rp_d    = rp_q;
            count_d = count_q;
            dout_d  = dout_q;
            valid_d = 1'b0;
            if (flush_a[g]) begin
                wp_d    = '0;
                rp_d    = '0;
                count_d = '0;
            end else begin
                if (wr_ok) begin
                    wp_d = wp_q + AW'(1);
                end
                if (rd_ok) begin
                    rp_d    = rp_q + AW'(1);
                    dout_d  = mem[rp_q];
                    valid_d = 1'b1;
                end
                if (wr_ok && !rd_ok) begin
                    count_d = count_q + CW'(1);
                end else if (rd_ok && !wr_ok) begin
                    count_d = count_q - CW'(1);
                end
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                wp_q    <= '0;
                rp_q    <= '0;
                count_q <= '0;
                dout_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                wp_q    <= wp_d;
                rp_q    <= rp_d;
                count_q <= count_d;
                dout_q  <= dout_d;
                valid_q <= valid_d;
            end
        end

        // Storage has no reset; contents are only visible through the pointers.
        always_ff @(posedge clk) begin
            if (!flush_a[g] && wr_ok) begin
                mem[wp_q] <= din_a[g];
            end
        end

        assign dout_a[g]  = dout_q;
        assign valid_a[g] = valid_q;
        assign full_a[g]  = full;
        assign empty_a[g] = empty;
        assign afull_a[g] = (count_q >= CW'(AFULL_THRESH));
        assign count_a[g] = count_q;

`ifdef BC_BUF_ERR_FLAGS_EN
        logic ovf_q, ovf_d, unf_q, unf_d;

        always_comb begin
            ovf_d = ovf_q;
            unf_d = unf_q;
            if (flush_a[g]) begin
                ovf_d = 1'b0;
                unf_d = 1'b0;
            end else begin
                if (wr_en_a[g] && full && !rd_ok) begin
                    ovf_d = 1'b1;
                end
                if (rd_en_a[g] && empty) begin
                    unf_d = 1'b1;
                end
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                ovf_q <= 1'b0;
                unf_q <= 1'b0;
            end else begin
                ovf_q <= ovf_d;
                unf_q <= unf_d;
            end
        end

        assign ovf_a[g] = ovf_q;
        assign unf_a[g] = unf_q;
`endif
    end

endmodule

// File: tb/tb_bc_duplex_buffer.sv
// Self-checking bench for bc_duplex_buffer (WIDTH=16, DEPTH=8, AFULL_THRESH=6).
// A queue model of each FIFO pushes expected read words into a scoreboard; a
// monitor pops and compares them whenever the DUT raises valid.

module tb_bc_duplex_buffer;

    localparam int WIDTH = 16;
    localparam int DEPTH = 8;
    localparam int AFT   = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_wr_en = 1'b0, in_rd_en = 1'b0, in_flush = 1'b0;
    logic        out_wr_en = 1'b0, out_rd_en = 1'b0, out_flush = 1'b0;
    logic [15:0] in_din = '0, out_din = '0;
    logic [15:0] in_dout, out_dout;
    logic        in_valid, in_full, in_afull, in_empty;
    logic        out_valid, out_full, out_afull, out_empty;
    logic [3:0]  in_count, out_count;
`ifdef BC_BUF_ERR_FLAGS_EN
    logic        in_ovf, in_unf, out_ovf, out_unf;
    bit          m_ovf [2];
    bit          m_unf [2];
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] mq_in[$], mq_out[$];   // model contents
    logic [15:0] ex_in[$], ex_out[$];   // scoreboard of expected read words
    logic [15:0] ld_in = '0, ld_out = '0;

    always #5 clk = ~clk;

    bc_duplex_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_THRESH(AFT)) dut (
        .clk(clk), .rst(rst),
        .in_wr_en(in_wr_en), .in_din(in_din), .in_rd_en(in_rd_en), .in_flush(in_flush),
        .in_dout(in_dout), .in_valid(in_valid), .in_full(in_full), .in_afull(in_afull),
        .in_empty(in_empty), .in_count(in_count),
        .out_wr_en(out_wr_en), .out_din(out_din), .out_rd_en(out_rd_en),
        .out_flush(out_flush), .out_dout(out_dout), .out_valid(out_valid),
        .out_full(out_full), .out_afull(out_afull), .out_empty(out_empty),
        .out_count(out_count)
`ifdef BC_BUF_ERR_FLAGS_EN
        , .in_ovf(in_ovf), .in_unf(in_unf), .out_ovf(out_ovf), .out_unf(out_unf)
`endif
    );

    // Scoreboard monitor, sampled mid-cycle.
    always @(negedge clk) begin
        logic [15:0] v;
        if (rst && in_valid) begin
            n_checks++;
            if (ex_in.size() == 0) begin
                n_fail++;
                $display("FAIL in_unexpected_valid dout=%h", in_dout);
            end else begin
                v = ex_in.pop_front();
                if (in_dout !== v) begin
                    n_fail++;
                    $display("FAIL in_read_data got=%h exp=%h", in_dout, v);
                end
            end
        end
        if (rst && out_valid) begin
            n_checks++;
            if (ex_out.size() == 0) begin
                n_fail++;
                $display("FAIL out_unexpected_valid dout=%h", out_dout);
            end else begin
                v = ex_out.pop_front();
                if (out_dout !== v) begin
                    n_fail++;
                    $display("FAIL out_read_data got=%h exp=%h", out_dout, v);
                end
            end
        end
    end

    task automatic idle();
        in_wr_en = 0; in_rd_en = 0; in_flush = 0;
        out_wr_en = 0; out_rd_en = 0; out_flush = 0;
    endtask

    // Advance the model with the currently driven inputs, then clock the DUT.
    task automatic step();
        bit rok, wok;
        logic [15:0] v;
        if (in_flush) begin
            mq_in.delete();
`ifdef BC_BUF_ERR_FLAGS_EN
            m_ovf[0] = 0; m_unf[0] = 0;
`endif
        end else begin
            rok = in_rd_en && mq_in.size() > 0;
            wok = in_wr_en && (mq_in.size() < DEPTH || rok);
`ifdef BC_BUF_ERR_FLAGS_EN
            if (in_wr_en && mq_in.size() == DEPTH && !rok) m_ovf[0] = 1;
            if (in_rd_en && mq_in.size() == 0) m_unf[0] = 1;
`endif
            if (rok) begin v = mq_in.pop_front(); ex_in.push_back(v); ld_in = v; end
            if (wok) mq_in.push_back(in_din);
        end
        if (out_flush) begin
            mq_out.delete();
`ifdef BC_BUF_ERR_FLAGS_EN
            m_ovf[1] = 0; m_unf[1] = 0;
`endif
        end else begin
            rok = out_rd_en && mq_out.size() > 0;
            wok = out_wr_en && (mq_out.size() < DEPTH || rok);
`ifdef BC_BUF_ERR_FLAGS_EN
            if (out_wr_en && mq_out.size() == DEPTH && !rok) m_ovf[1] = 1;
            if (out_rd_en && mq_out.size() == 0) m_unf[1] = 1;
`endif
            if (rok) begin v = mq_out.pop_front(); ex_out.push_back(v); ld_out = v; end
            if (wok) mq_out.push_back(out_din);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 0;
        #3;
        n_checks += 10;
        if (in_empty !== 1'b1) begin n_fail++; $display("FAIL rst_in_empty got=%b exp=1", in_empty); end
        if (in_count !== 4'd0) begin n_fail++; $display("FAIL rst_in_count got=%0d exp=0", in_count); end
        if (in_dout !== 16'h0) begin n_fail++; $display("FAIL rst_in_dout got=%h exp=0000", in_dout); end
        if (in_valid !== 1'b0) begin n_fail++; $display("FAIL rst_in_valid got=%b exp=0", in_valid); end
        if ({in_full, in_afull} !== 2'b00) begin n_fail++; $display("FAIL rst_in_full_afull got=%b exp=00", {in_full, in_afull}); end
        if (out_empty !== 1'b1) begin n_fail++; $display("FAIL rst_out_empty got=%b exp=1", out_empty); end
        if (out_count !== 4'd0) begin n_fail++; $display("FAIL rst_out_count got=%0d exp=0", out_count); end
        if (out_dout !== 16'h0) begin n_fail++; $display("FAIL rst_out_dout got=%h exp=0000", out_dout); end
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        if ({out_full, out_afull} !== 2'b00) begin n_fail++; $display("FAIL rst_out_full_afull got=%b exp=00", {out_full, out_afull}); end
        @(posedge clk); #1;
        rst = 1;
        idle();
        repeat (2) step();
        n_checks++;
        if (in_empty !== 1'b1 || out_empty !== 1'b1) begin
            n_fail++; $display("FAIL idle_empty got=%b%b exp=11", in_empty, out_empty);
        end
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= DEPTH; i++) begin
            in_wr_en = 1; in_din = 16'(i);
            step();
            n_checks += 3;
            if (in_count !== 4'(i)) begin n_fail++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, in_count, i); end
            if (in_afull !== (i >= AFT)) begin n_fail++; $display("FAIL fill_afull[%0d] got=%b exp=%b", i, in_afull, i >= AFT); end
            if (in_full !== (i == DEPTH)) begin n_fail++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, in_full, i == DEPTH); end
        end
        in_din = 16'h00FF;
        step();
        n_checks++;
        if (in_count !== 4'(mq_in.size()) || in_full !== 1'b1) begin
            n_fail++; $display("FAIL drop_when_full count=%0d full=%b exp=8/1", in_count, in_full);
        end
`ifdef BC_BUF_ERR_FLAGS_EN
        n_checks++;
        if (in_ovf !== m_ovf[0]) begin n_fail++; $display("FAIL in_ovf got=%b exp=%b", in_ovf, m_ovf[0]); end
`endif
        in_wr_en = 0; in_rd_en = 1;
        for (int i = 0; i < DEPTH; i++) begin
            step();
            n_checks++;
            if (in_valid !== 1'b1) begin n_fail++; $display("FAIL drain_valid[%0d] got=%b exp=1", i, in_valid); end
        end
        in_rd_en = 0;
        step();
        n_checks += 3;
        if (in_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid_end got=%b exp=0", in_valid); end
        if (in_empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty got=%b exp=1", in_empty); end
        if (ex_in.size() != 0) begin n_fail++; $display("FAIL drain_missing got=%0d words exp=0", ex_in.size()); end
    endtask

    task automatic test_wrap();
        for (int r = 0; r < 4; r++) begin
            out_rd_en = 0; out_wr_en = 1;
            for (int i = 0; i < 5; i++) begin
                out_din = 16'(16'h0100 + r * 16 + i);
                step();
            end
            out_wr_en = 0; out_rd_en = 1;
            repeat (5) step();
            out_rd_en = 0;
            step();
            n_checks += 2;
            if (out_count !== 4'd0) begin n_fail++; $display("FAIL wrap_count[%0d] got=%0d exp=0", r, out_count); end
            if (ex_out.size() != 0) begin n_fail++; $display("FAIL wrap_missing[%0d] got=%0d exp=0", r, ex_out.size()); end
        end
    endtask

    task automatic test_full_rw();
        in_wr_en = 1;
        for (int i = 0; i < DEPTH; i++) begin
            in_din = 16'(16'h0200 + i);
            step();
        end
        in_rd_en = 1;
        for (int i = 0; i < 3; i++) begin
            in_din = 16'(16'h0300 + i);
            step();
            n_checks += 2;
            if (in_count !== 4'd8) begin n_fail++; $display("FAIL full_rw_count[%0d] got=%0d exp=8", i, in_count); end
            if (in_valid !== 1'b1) begin n_fail++; $display("FAIL full_rw_valid[%0d] got=%b exp=1", i, in_valid); end
        end
        in_wr_en = 0;
        repeat (DEPTH) step();
        in_rd_en = 0;
        step();
        n_checks += 2;
        if (in_count !== 4'd0) begin n_fail++; $display("FAIL full_rw_end_count got=%0d exp=0", in_count); end
        if (ex_in.size() != 0) begin n_fail++; $display("FAIL full_rw_missing got=%0d exp=0", ex_in.size()); end
    endtask

    task automatic test_empty_rw();
        in_wr_en = 1; in_rd_en = 1; in_din = 16'hABCD;
        step();
        n_checks += 2;
        if (in_valid !== 1'b0) begin n_fail++; $display("FAIL empty_rw_valid got=%b exp=0", in_valid); end
        if (in_count !== 4'd1) begin n_fail++; $display("FAIL empty_rw_count got=%0d exp=1", in_count); end
`ifdef BC_BUF_ERR_FLAGS_EN
        n_checks++;
        if (in_unf !== m_unf[0]) begin n_fail++; $display("FAIL in_unf got=%b exp=%b", in_unf, m_unf[0]); end
`endif
        in_wr_en = 0;
        step();
        in_rd_en = 0;
        step();
        n_checks++;
        if (ex_in.size() != 0 || in_dout !== 16'hABCD) begin
            n_fail++; $display("FAIL empty_rw_readback got=%h exp=abcd", in_dout);
        end
    endtask

    task automatic test_flush_reset();
        in_wr_en = 1; out_wr_en = 1;
        for (int i = 0; i < 4; i++) begin
            in_din = 16'(16'h0400 + i); out_din = 16'(16'h0500 + i);
            if (i == 2) out_wr_en = 0;
            step();
        end
        in_wr_en = 0;
        in_rd_en = 1;
        step();
        in_flush = 1; in_wr_en = 1; in_rd_en = 1; in_din = 16'hDEAD;
        step();
        idle();
        n_checks += 5;
        if (in_count !== 4'd0) begin n_fail++; $display("FAIL flush_count got=%0d exp=0", in_count); end
        if (in_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got=%b exp=0", in_valid); end
        if (in_dout !== ld_in) begin n_fail++; $display("FAIL flush_dout_hold got=%h exp=%h", in_dout, ld_in); end
        if (in_empty !== 1'b1) begin n_fail++; $display("FAIL flush_empty got=%b exp=1", in_empty); end
        if (out_count !== 4'(mq_out.size())) begin n_fail++; $display("FAIL flush_out_count got=%0d exp=%0d", out_count, mq_out.size()); end
`ifdef BC_BUF_ERR_FLAGS_EN
        n_checks++;
        if ({in_ovf, in_unf, out_ovf, out_unf} !== {m_ovf[0], m_unf[0], m_ovf[1], m_unf[1]}) begin
            n_fail++; $display("FAIL flush_err_flags got=%b exp=%b", {in_ovf, in_unf, out_ovf, out_unf},
                                {m_ovf[0], m_unf[0], m_ovf[1], m_unf[1]});
        end
`endif
        step();
        n_checks++;
        if (in_valid !== 1'b0 || in_count !== 4'd0) begin
            n_fail++; $display("FAIL flush_write_discarded valid=%b count=%0d exp=0/0", in_valid, in_count);
        end
        out_rd_en = 1;
        repeat (2) step();
        out_rd_en = 0;
        // Mid-burst reset.
        in_wr_en = 1; out_wr_en = 1;
        for (int i = 0; i < 3; i++) begin
            in_din = 16'(16'h0600 + i); out_din = 16'(16'h0700 + i);
            step();
        end
        rst = 0;
        #1;
        idle();
        mq_in.delete(); mq_out.delete(); ex_in.delete(); ex_out.delete();
        n_checks += 4;
        if ({in_count, out_count} !== 8'h00) begin n_fail++; $display("FAIL rst_mid_count got=%h exp=00", {in_count, out_count}); end
        if ({in_empty, out_empty, in_full, out_full} !== 4'b1100) begin
            n_fail++; $display("FAIL rst_mid_flags got=%b exp=1100", {in_empty, out_empty, in_full, out_full});
        end
        if ({in_dout, out_dout} !== 32'h0) begin n_fail++; $display("FAIL rst_mid_dout got=%h exp=0", {in_dout, out_dout}); end
        if ({in_valid, out_valid, in_afull, out_afull} !== 4'b0000) begin
            n_fail++; $display("FAIL rst_mid_valid_afull got=%b exp=0000", {in_valid, out_valid, in_afull, out_afull});
        end
`ifdef BC_BUF_ERR_FLAGS_EN
        m_ovf[0] = 0; m_ovf[1] = 0; m_unf[0] = 0; m_unf[1] = 0;
        n_checks++;
        if ({in_ovf, in_unf, out_ovf, out_unf} !== 4'b0000) begin
            n_fail++; $display("FAIL rst_mid_err got=%b exp=0000", {in_ovf, in_unf, out_ovf, out_unf});
        end
`endif
        @(posedge clk); #1;
        rst = 1;
        in_wr_en = 1; in_din = 16'h5555;
        step();
        in_wr_en = 0; in_rd_en = 1;
        n_checks++;
        if (in_count !== 4'd1) begin n_fail++; $display("FAIL post_rst_write got=%0d exp=1", in_count); end
        step();
        in_rd_en = 0;
        step();
        n_checks++;
        if (ex_in.size() != 0 || in_dout !== 16'h5555) begin
            n_fail++; $display("FAIL post_rst_read got=%h exp=5555", in_dout);
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_wrap();
        test_full_rw();
        test_empty_rw();
        test_flush_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
